// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port.
// After reset it can sweep every register to zero, because the BRAM-backed file has no reset.
module rf_wb_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned DATAW    = 32,
    parameter int unsigned ADDRW    = 6,
    parameter int unsigned CLR_INIT = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ADDRW-1:0]   req_addr,
    input  logic [NREQ*DATAW-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    we3,
    output logic [ADDRW-1:0]        a3,
    output logic [DATAW-1:0]        wd3,
    output logic                    init_done
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] S_CLR = 1'b0;
    localparam logic [0:0] S_RUN = 1'b1;

    localparam logic [ADDRW-1:0] CNT_LAST = {ADDRW{1'b1}};
    localparam logic [PTRW-1:0]  PTR_LAST = PTRW'(NREQ - 1);
    localparam logic [0:0]       S_RESET  = (CLR_INIT != 0) ? S_CLR : S_RUN;
    localparam logic             INIT_RST = (CLR_INIT != 0) ? 1'b0 : 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [ADDRW-1:0] clr_cnt_q,   clr_cnt_d;
    logic [PTRW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic             we3_q,       we3_d;
    logic [ADDRW-1:0] a3_q,        a3_d;
    logic [DATAW-1:0] wd3_q,       wd3_d;
    logic             init_done_q, init_done_d;

    logic [NREQ-1:0]  grant_c;
    logic             grant_any_c;
    logic [PTRW-1:0]  grant_idx_c;
    logic [ADDRW-1:0] grant_addr_c;
    logic [DATAW-1:0] grant_data_c;
    int               arb_idx_c;

    // Round-robin search starting at rr_ptr; only grants in RUN and never depends on req_ready.
    always_comb begin
        grant_c     = '0;
        grant_any_c = 1'b0;
        grant_idx_c = '0;
        arb_idx_c   = 0;
        if (state_q == S_RUN) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                arb_idx_c = int'(rr_ptr_q) + k;
                if (arb_idx_c >= int'(NREQ)) begin
                    arb_idx_c = arb_idx_c - int'(NREQ);
                end
                if (!grant_any_c && req_valid[arb_idx_c]) begin
                    grant_any_c = 1'b1;
                    grant_idx_c = PTRW'(arb_idx_c);
                end
            end
            if (grant_any_c) begin
                grant_c[grant_idx_c] = 1'b1;
            end
        end
    end

    // One-hot select of the granted requester's address and data.
    always_comb begin
        grant_addr_c = '0;
        grant_data_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_c[i]) begin
                grant_addr_c = grant_addr_c | req_addr[i*ADDRW +: ADDRW];
                grant_data_c = grant_data_c | req_data[i*DATAW +: DATAW];
            end
        end
    end

    // Next-state logic: zero-sweep in CLR, granted writeback in RUN.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        we3_d       = 1'b0;
        a3_d        = a3_q;
        wd3_d       = wd3_q;
        init_done_d = init_done_q;
        case (state_q)
            S_CLR: begin
                we3_d     = 1'b1;
                a3_d      = clr_cnt_q;
                wd3_d     = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                if (grant_any_c) begin
                    // r0 writes complete the handshake but never reach the file
                    we3_d    = (grant_addr_c != '0);
                    a3_d     = grant_addr_c;
                    wd3_d    = grant_data_c;
                    rr_ptr_d = (grant_idx_c == PTR_LAST) ? '0 : grant_idx_c + 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_RESET;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            we3_q       <= 1'b0;
            a3_q        <= '0;
            wd3_q       <= '0;
            init_done_q <= INIT_RST;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            we3_q       <= we3_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            init_done_q <= init_done_d;
        end
    end

    assign req_ready = grant_c;
    assign we3       = we3_q;
    assign a3        = a3_q;
    assign wd3       = wd3_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int NREQ  = 3;
    localparam int DATAW = 32;
    localparam int ADDRW = 6;
    localparam int NREG  = 1 << ADDRW;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*DATAW-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  we3;
    logic [ADDRW-1:0]      a3;
    logic [DATAW-1:0]      wd3;
    logic                  init_done;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .ADDRW(ADDRW), .CLR_INIT(1)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .we3(we3), .a3(a3), .wd3(wd3), .init_done(init_done)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Pending requests per requester (held stable until granted)
    bit               p_v [NREQ];
    logic [ADDRW-1:0] p_a [NREQ];
    logic [DATAW-1:0] p_d [NREQ];

    // Behavioural model
    bit               m_run;
    int               m_cnt;
    int               m_ptr;
    bit               m_we;
    logic [ADDRW-1:0] m_a;
    logic [DATAW-1:0] m_wd;
    bit               m_init;
    int               last_grant;
    logic [NREQ-1:0]  obs_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                = p_v[i];
            req_addr[i*ADDRW +: ADDRW]  = p_a[i];
            req_data[i*DATAW +: DATAW]  = p_d[i];
        end
    endtask

    function automatic int pick();
        if (!m_run) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (p_v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            p_v[i] = 1'b0;
            p_a[i] = '0;
            p_d[i] = '0;
        end
    endtask

    // One clock: check grant mid-cycle, advance model, check registered outputs after edge.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_ready;
        apply();
        #3;
        g = pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (!m_run) begin
            m_we = 1'b1;
            m_a  = ADDRW'(m_cnt);
            m_wd = '0;
            m_cnt++;
            if (m_cnt == NREG) begin
                m_run  = 1'b1;
                m_init = 1'b1;
            end
        end else if (g >= 0) begin
            m_we = (p_a[g] != 0);
            if (m_we) begin
                m_a  = p_a[g];
                m_wd = p_d[g];
            end
            m_ptr = (g + 1) % NREQ;
            p_v[g] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        last_grant = g;
        @(posedge clk);
        #1;
        chk("we3", 64'(we3), 64'(m_we));
        chk("init_done", 64'(init_done), 64'(m_init));
        if (m_we) begin
            chk("a3", 64'(a3), 64'(m_a));
            chk("wd3", 64'(wd3), 64'(m_wd));
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        apply();
        @(posedge clk);
        #1;
        m_run = 1'b0; m_cnt = 0; m_ptr = 0;
        m_we = 1'b0; m_a = '0; m_wd = '0; m_init = 1'b0;
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_a3", 64'(a3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_init", 64'(init_done), 64'd0);
        rstn = 1'b1;
    endtask

    task automatic rand_fill();
        for (int i = 0; i < NREQ; i++) begin
            if (!p_v[i] && ($urandom_range(0, 1) == 1)) begin
                p_v[i] = 1'b1;
                p_a[i] = ($urandom_range(0, 5) == 0) ? '0 : ADDRW'($urandom);
                p_d[i] = DATAW'($urandom);
            end
        end
    endtask

    int seq3 [6] = '{0, 1, 2, 0, 1, 2};
    int waited;

    initial begin
        rstn = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        clear_reqs();
        #2;

        // 1: reset then full sweep, with requests pending that must not be granted
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            p_v[i] = 1'b1; p_a[i] = ADDRW'(i + 10); p_d[i] = DATAW'(32'h100 + i);
        end
        for (int c = 0; c < NREG; c++) begin
            step();
            chk("sweep_a3", 64'(a3), 64'(c));
            chk("sweep_ready", 64'(obs_ready), 64'd0);
        end
        chk("init_after_sweep", 64'(init_done), 64'd1);

        // 3: all valid, grants 0,1,2,0,1,2 from rr_ptr=0
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_v[i]) begin
                    p_v[i] = 1'b1; p_a[i] = ADDRW'(20 + c); p_d[i] = DATAW'(32'hA000 + c);
                end
            end
            step();
            chk("rr_seq", 64'(obs_ready), 64'(1) << seq3[c]);
            chk("rr_we3", 64'(we3), 64'd1);
        end
        clear_reqs();
        step();

        // 2: only req1 valid
        p_v[1] = 1'b1; p_a[1] = ADDRW'(5); p_d[1] = 32'hDEADBEEF;
        step();
        chk("t2_ready", 64'(obs_ready), 64'b010);
        chk("t2_a3", 64'(a3), 64'd5);
        chk("t2_wd3", 64'(wd3), 64'hDEADBEEF);

        // 4: req2 writes r0 -> accepted, no write, pointer wraps to 0
        p_v[2] = 1'b1; p_a[2] = '0; p_d[2] = 32'h12345678;
        step();
        chk("t4_ready", 64'(obs_ready), 64'b100);
        chk("t4_we3", 64'(we3), 64'd0);
        p_v[0] = 1'b1; p_v[1] = 1'b1; p_a[0] = ADDRW'(7); p_a[1] = ADDRW'(8);
        p_d[0] = 32'h7; p_d[1] = 32'h8;
        step();
        chk("t4_ptr0", 64'(obs_ready), 64'b001);
        step();
        clear_reqs();

        // 6: req0 held behind req1/req2 (rr_ptr=1 after a req0-only grant)
        p_v[0] = 1'b1; p_a[0] = ADDRW'(3); p_d[0] = 32'h11;
        step();
        p_v[0] = 1'b1; p_a[0] = ADDRW'(9);  p_d[0] = 32'hC0FFEE00;
        p_v[1] = 1'b1; p_a[1] = ADDRW'(10); p_d[1] = 32'h1;
        p_v[2] = 1'b1; p_a[2] = ADDRW'(11); p_d[2] = 32'h2;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!obs_ready[0] && waited < 5);
        chk("t6_wait", 64'(waited), 64'd3);
        chk("t6_a3", 64'(a3), 64'd9);
        chk("t6_wd3", 64'(wd3), 64'hC0FFEE00);
        clear_reqs();

        // 5: reset at sweep count 20 restarts the sweep
        do_reset();
        for (int c = 0; c < 20; c++) step();
        do_reset();
        for (int c = 0; c < NREG; c++) begin
            step();
            chk("resweep_a3", 64'(a3), 64'(c));
            if (c < NREG - 1) chk("resweep_init", 64'(init_done), 64'd0);
        end

        // Random traffic with hold-until-granted requesters
        for (int c = 0; c < 400; c++) begin
            rand_fill();
            step();
        end
        clear_reqs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
